// File: rtl/prbs_pkg.sv
// Shared types and constants for the PRBS-15 checker.
package prbs_pkg;

  typedef enum logic [1:0] {IDLE, HUNT, CHECK, LOCKED} state_t;

  localparam int TAP_A = 13;
  localparam int TAP_B = 14;
  localparam int CNT_W = 16;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/prbs_15_expect.sv
// Expected-stream model: tracks the generator's word, byte lane and repeat count.
module prbs_15_expect
  import prbs_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        cfg_load,
  input  logic        adv,
  input  logic [31:0] pattern,
  input  logic [3:0]  n,
  output logic [7:0]  exp_byte
);

  logic [31:0] exp;
  logic [1:0]  byte_sel;
  logic [3:0]  rep_cnt;
  logic [3:0]  n_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp      <= '0;
      byte_sel <= '0;
      rep_cnt  <= '0;
      n_q      <= '0;
    end else begin
      if (cfg_load) n_q <= n;
      if (load) begin
        exp      <= pattern;
        byte_sel <= '0;
        rep_cnt  <= '0;
      end else if (adv) begin
        byte_sel <= byte_sel + 2'd1;
        // the word only steps once it has been repeated n_q times
        if (byte_sel == 2'd3) begin
          if (rep_cnt + 4'd1 == n_q) begin
            exp     <= {exp[30:0], exp[TAP_A] ^ exp[TAP_B]};
            rep_cnt <= '0;
          end else begin
            rep_cnt <= rep_cnt + 4'd1;
          end
        end
      end
    end
  end

  always_comb begin
    case (byte_sel)
      2'd0:    exp_byte = exp[31:24];
      2'd1:    exp_byte = exp[23:16];
      2'd2:    exp_byte = exp[15:8];
      default: exp_byte = exp[7:0];
    endcase
  end

endmodule

// File: rtl/prbs_15_checker.sv
// PRBS-15 byte-stream checker with lock/loss hysteresis and error counters.
// Define PRBS_CHK_BIT_ERR_EN to enable the per-bit error counter.
module prbs_15_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_CNT = 8,
  parameter int LOSS_CNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      pattern,
  input  logic [3:0]       n,
  input  logic [7:0]       data_in,
  input  logic             data_valid,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic             cfg_err,
  output logic [CNT_W-1:0] bit_err_count
);

  localparam int RUN_W  = $clog2(LOCK_CNT + 1);
  localparam int MISS_W = $clog2(LOSS_CNT + 1);

  state_t            state, state_d;
  logic [RUN_W-1:0]  run, run_d;
  logic [MISS_W-1:0] miss, miss_d;
  logic              cfg_err_d;
  logic              load, cfg_load, adv, err_hit, clr_cnt;
  logic [7:0]        exp_byte;
  logic              match;

  prbs_15_expect u_expect (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .cfg_load (cfg_load),
    .adv      (adv),
    .pattern  (pattern),
    .n        (n),
    .exp_byte (exp_byte)
  );

  assign match  = (data_in == exp_byte);
  assign locked = (state == LOCKED);

  always_comb begin
    state_d   = state;
    run_d     = run;
    miss_d    = miss;
    cfg_err_d = cfg_err;
    load      = 1'b0;
    cfg_load  = 1'b0;
    adv       = 1'b0;
    err_hit   = 1'b0;
    clr_cnt   = 1'b0;
    if (!start) begin
      state_d   = IDLE;
      cfg_err_d = 1'b0;
    end else begin
      case (state)
        IDLE: if (!cfg_err) begin
          if (n == 4'd0) begin
            cfg_err_d = 1'b1;
          end else begin
            load     = 1'b1;
            cfg_load = 1'b1;
            clr_cnt  = 1'b1;
            run_d    = '0;
            miss_d   = '0;
            state_d  = HUNT;
          end
        end
        // model already sits at pattern/lane 0 here, so a hit just advances it
        HUNT: if (data_valid && data_in == pattern[31:24]) begin
          adv     = 1'b1;
          run_d   = RUN_W'(1);
          state_d = CHECK;
        end
        CHECK: if (data_valid) begin
          if (match) begin
            adv   = 1'b1;
            run_d = run + RUN_W'(1);
            if (run + RUN_W'(1) == RUN_W'(LOCK_CNT)) begin
              miss_d  = '0;
              state_d = LOCKED;
            end
          end else begin
            load    = 1'b1;
            run_d   = '0;
            state_d = HUNT;
          end
        end
        LOCKED: if (data_valid) begin
          if (match) begin
            adv    = 1'b1;
            miss_d = '0;
          end else begin
            err_hit = 1'b1;
            if (miss + MISS_W'(1) == MISS_W'(LOSS_CNT)) begin
              load    = 1'b1;
              miss_d  = '0;
              run_d   = '0;
              state_d = HUNT;
            end else begin
              adv    = 1'b1;
              miss_d = miss + MISS_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      run       <= '0;
      miss      <= '0;
      cfg_err   <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_d;
      run       <= run_d;
      miss      <= miss_d;
      cfg_err   <= cfg_err_d;
      err_pulse <= err_hit;
      if (clr_cnt)
        err_count <= '0;
      else if (err_hit && err_count != '1)
        err_count <= err_count + CNT_W'(1);
    end
  end

`ifdef PRBS_CHK_BIT_ERR_EN
  logic [CNT_W:0]   bit_sum;
  logic [CNT_W-1:0] bit_cnt;

  assign bit_sum = {1'b0, bit_cnt} + (CNT_W+1)'(popcount8(data_in ^ exp_byte));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bit_cnt <= '0;
    else if (clr_cnt)
      bit_cnt <= '0;
    else if (err_hit)
      bit_cnt <= bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
  end

  assign bit_err_count = bit_cnt;
`else
  assign bit_err_count = '0;
`endif

endmodule

// File: tb/tb_prbs_15_checker.sv
// Bench for prbs_15_checker: table-driven lock/err stream plus config and reset sequences.
module tb_prbs_15_checker;
  import prbs_pkg::*;

`ifdef PRBS_CHK_BIT_ERR_EN
  localparam bit BE_ON = 1'b1;
`else
  localparam bit BE_ON = 1'b0;
`endif

  typedef struct {
    logic        locked;
    logic        pulse;
    logic [15:0] errs;
    logic [15:0] bits;
    logic        cfg;
  } exp_t;

  typedef struct {
    logic       valid;
    logic [7:0] data;
    exp_t       e;
  } vec_t;

  logic        clk, rst_n, start, data_valid;
  logic [31:0] pattern;
  logic [3:0]  n;
  logic [7:0]  data_in;
  logic        locked, err_pulse, cfg_err;
  logic [15:0] err_count, bit_err_count;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  vec_t tbl[$];

  prbs_15_checker dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .pattern       (pattern),
    .n             (n),
    .data_in       (data_in),
    .data_valid    (data_valid),
    .locked        (locked),
    .err_pulse     (err_pulse),
    .err_count     (err_count),
    .cfg_err       (cfg_err),
    .bit_err_count (bit_err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic l, input logic p, input int e, input int b, input logic c);
    exp_t r;
    r.locked = l; r.pulse = p; r.errs = 16'(e); r.bits = BE_ON ? 16'(b) : 16'd0; r.cfg = c;
    return r;
  endfunction

  task automatic add(input logic v, input logic [7:0] d, input logic l, input logic p,
                     input int e, input int b);
    vec_t t;
    t.valid = v; t.data = d; t.e = mk(l, p, e, b, 1'b0);
    tbl.push_back(t);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      cmp({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    cmp({tag, "_locked"}, {31'd0, locked}, {31'd0, e.locked});
    cmp({tag, "_pulse"},  {31'd0, err_pulse}, {31'd0, e.pulse});
    cmp({tag, "_errs"},   {16'd0, err_count}, {16'd0, e.errs});
    cmp({tag, "_bits"},   {16'd0, bit_err_count}, {16'd0, e.bits});
    cmp({tag, "_cfg"},    {31'd0, cfg_err}, {31'd0, e.cfg});
  endtask

  // drive one cycle of stimulus, queue its expectation, compare after the edge
  task automatic step(input string tag, input logic v, input logic [7:0] d, input exp_t e);
    data_valid = v;
    data_in    = d;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    pop_check(tag);
  endtask

  initial begin
    logic [7:0] w0b[4];
    logic [7:0] w1b[4];
    w0b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    w1b = '{8'hBD, 8'h5B, 8'h7D, 8'hDF};

    rst_n = 1'b0; start = 1'b0; pattern = 32'hDEADBEEF; n = 4'd2;
    data_in = 8'h00; data_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(mk(0, 0, 0, 0, 0));
    pop_check("reset");
    rst_n = 1'b1;

    // word 0 twice -> lock on the 8th byte
    add(1, 8'hDE, 0, 0, 0, 0);
    add(1, 8'hAD, 0, 0, 0, 0);
    add(1, 8'hBE, 0, 0, 0, 0);
    add(1, 8'hEF, 0, 0, 0, 0);
    add(1, 8'hDE, 0, 0, 0, 0);
    add(1, 8'hAD, 0, 0, 0, 0);
    add(1, 8'hBE, 0, 0, 0, 0);
    add(1, 8'hEF, 1, 0, 0, 0);
    add(0, 8'h00, 1, 0, 0, 0);
    // advanced word, first repeat, with a valid-low gap
    add(1, 8'hBD, 1, 0, 0, 0);
    add(1, 8'h5B, 1, 0, 0, 0);
    add(0, 8'h00, 1, 0, 0, 0);
    add(1, 8'h7D, 1, 0, 0, 0);
    add(1, 8'hDF, 1, 0, 0, 0);
    // second repeat with one single-bit error
    add(1, 8'hBC, 1, 1, 1, 1);
    add(1, 8'h5B, 1, 0, 1, 1);
    add(1, 8'h7D, 1, 0, 1, 1);
    add(1, 8'hDF, 1, 0, 1, 1);
    // word 0x7AB6FBBE replaced by zeros -> loss of lock on the 4th
    add(1, 8'h00, 1, 1, 2, 6);
    add(1, 8'h00, 1, 1, 3, 11);
    add(1, 8'h00, 1, 1, 4, 18);
    add(1, 8'h00, 0, 1, 5, 24);
    add(1, 8'h11, 0, 0, 5, 24);
    add(0, 8'hDE, 0, 0, 5, 24);

    start = 1'b1;
    step("start", 1'b0, 8'h00, mk(0, 0, 0, 0, 0));
    step("hunt_junk", 1'b1, 8'h55, mk(0, 0, 0, 0, 0));
    for (int i = 0; i < tbl.size(); i++)
      step($sformatf("vec%0d", i), tbl[i].valid, tbl[i].data, tbl[i].e);

    // start low: valid byte ignored, counters hold; restart clears them
    start = 1'b0;
    step("stop_hold", 1'b1, 8'hDE, mk(0, 0, 5, 24, 0));
    start = 1'b1;
    step("restart_clr", 1'b0, 8'h00, mk(0, 0, 0, 0, 0));

    // n = 0 configuration error
    start = 1'b0;
    step("cfg_idle", 1'b0, 8'h00, mk(0, 0, 0, 0, 0));
    n = 4'd0; start = 1'b1;
    step("cfg_set", 1'b0, 8'h00, mk(0, 0, 0, 0, 1));
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 4; k++)
        step($sformatf("cfg_nolock%0d", r*4+k), 1'b1, w0b[k], mk(0, 0, 0, 0, 1));
    start = 1'b0;
    step("cfg_drop", 1'b0, 8'h00, mk(0, 0, 0, 0, 0));
    n = 4'd1; start = 1'b1;
    step("cfg_ok", 1'b0, 8'h00, mk(0, 0, 0, 0, 0));

    // n = 1: word advances after every 4 bytes
    for (int k = 0; k < 4; k++)
      step($sformatf("n1_w0_%0d", k), 1'b1, w0b[k], mk(0, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++)
      step($sformatf("n1_w1_%0d", k), 1'b1, w1b[k], mk(0, 0, 0, 0, 0));
    step("n1_lock", 1'b1, w1b[3], mk(1, 0, 0, 0, 0));
    step("n1_err", 1'b1, 8'h00, mk(1, 1, 1, 5, 0));

    // asynchronous reset mid-cycle while locked
    #3;
    rst_n = 1'b0;
    #1;
    cmp("arst_locked", {31'd0, locked}, 32'd0);
    cmp("arst_errs",   {16'd0, err_count}, 32'd0);
    cmp("arst_pulse",  {31'd0, err_pulse}, 32'd0);
    cmp("arst_bits",   {16'd0, bit_err_count}, 32'd0);
    cmp("arst_state",  {30'd0, dut.state}, {30'd0, IDLE});
    #10;
    rst_n = 1'b1;
    #10;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
